// File: rtl/p_det_scheduler_pkg.sv
// Shared types for the p_det scheduler: index type, default bound and FSM state encoding.
package p_det_scheduler_pkg;

    typedef logic [4:0] p_det_t;

    localparam int P_MAX_DEFAULT = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } sched_state_t;

endpackage

// File: rtl/p_det_scheduler_filter.sv
// Combinational accept/reject decision for a random p_det candidate.
// Optional feature macro: P_DET_NO_REPEAT_EN (also reject a repeat of the last accepted index).
module p_det_filter
    import p_det_scheduler_pkg::*;
#(
    parameter int P_MAX = P_MAX_DEFAULT
) (
    input  p_det_t cand,
    input  p_det_t prev,
    input  logic   prev_valid,
    output logic   accept
);

    localparam p_det_t P_MAX_V = p_det_t'(P_MAX);

    logic in_range;

    assign in_range = (cand != '0) && (cand <= P_MAX_V);

`ifdef P_DET_NO_REPEAT_EN
    // prev_valid stays low until the first acceptance after reset, exempting that draw
    assign accept = in_range && !(prev_valid && (cand == prev));
`else
    logic unused_prev;
    assign unused_prev = ^{prev, prev_valid};
    assign accept      = in_range;
`endif

endmodule

// File: rtl/p_det_scheduler.sv
// Draws a legal random p_det, holds it stable for SETTLE_CYC cycles, then launches the cipher core.
// Optional feature macro: P_DET_NO_REPEAT_EN (handled inside p_det_filter).
module p_det_scheduler
    import p_det_scheduler_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int P_MAX      = P_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rnd_valid,
    input  logic [4:0] rnd_data,
    output logic       rnd_ready,
    input  logic       core_done,
    output p_det_t     p_det,
    output logic       p_det_valid,
    output logic       core_start,
    output logic       busy,
    output logic [7:0] rej_cnt
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

    sched_state_t state_reg, state_next;
    p_det_t       p_det_reg, p_det_next;
    logic [7:0]   rej_cnt_reg, rej_cnt_next;
    logic [3:0]   settle_cnt_reg, settle_cnt_next;
    logic         core_start_reg, core_start_next;
    logic         have_prev_reg, have_prev_next;
    logic         accept;

    p_det_filter #(
        .P_MAX (P_MAX)
    ) u_filter (
        .cand       (rnd_data),
        .prev       (p_det_reg),
        .prev_valid (have_prev_reg),
        .accept     (accept)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            p_det_reg      <= '0;
            rej_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
            core_start_reg <= 1'b0;
            have_prev_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            p_det_reg      <= p_det_next;
            rej_cnt_reg    <= rej_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            core_start_reg <= core_start_next;
            have_prev_reg  <= have_prev_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        p_det_next      = p_det_reg;
        rej_cnt_next    = rej_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        core_start_next = 1'b0;
        have_prev_next  = have_prev_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                if (rnd_valid) begin
                    if (accept) begin
                        p_det_next      = rnd_data;
                        have_prev_next  = 1'b1;
                        settle_cnt_next = SETTLE_LOAD;
                        state_next      = SETTLE;
                    end else if (rej_cnt_reg != 8'hFF) begin
                        rej_cnt_next = rej_cnt_reg + 8'd1;
                    end
                end
            end
            SETTLE: begin
                // core_start is registered, so it rises together with the RUN state
                if (settle_cnt_reg <= 4'd1) begin
                    settle_cnt_next = 4'd0;
                    core_start_next = 1'b1;
                    state_next      = RUN;
                end else begin
                    settle_cnt_next = settle_cnt_reg - 4'd1;
                end
            end
            RUN: begin
                if (core_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rnd_ready   = (state_reg == DRAW);
    assign p_det_valid = (state_reg == SETTLE) || (state_reg == RUN);
    assign busy        = (state_reg != IDLE);
    assign p_det       = p_det_reg;
    assign core_start  = core_start_reg;
    assign rej_cnt     = rej_cnt_reg;

endmodule

// File: tb/tb_p_det_scheduler.sv
// Self-checking bench for p_det_scheduler: directed scenarios plus randomized draws against a behavioural model.
module tb_p_det_scheduler;
    import p_det_scheduler_pkg::*;

    localparam int SETTLE_CYC = 2;
    localparam int P_MAX      = 30;
    localparam int TIMEOUT    = 40;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic       rnd_valid = 1'b0;
    logic [4:0] rnd_data  = '0;
    logic       core_done = 1'b0;
    logic       rnd_ready;
    p_det_t     p_det;
    logic       p_det_valid;
    logic       core_start;
    logic       busy;
    logic [7:0] rej_cnt;

    int checks = 0;
    int errors = 0;

    // behavioural model: saturating reject count, last accepted index, acceptance of latest candidate
    int model_rej  = 0;
    int model_last = 0;
    bit model_have = 1'b0;
    bit model_acc  = 1'b0;

    always #5 clk = ~clk;

    p_det_scheduler #(
        .SETTLE_CYC (SETTLE_CYC),
        .P_MAX      (P_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rnd_valid   (rnd_valid),
        .rnd_data    (rnd_data),
        .rnd_ready   (rnd_ready),
        .core_done   (core_done),
        .p_det       (p_det),
        .p_det_valid (p_det_valid),
        .core_start  (core_start),
        .busy        (busy),
        .rej_cnt     (rej_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input int v);
        bit ok;
        ok = (v >= 1) && (v <= P_MAX);
`ifdef P_DET_NO_REPEAT_EN
        if (model_have && (v == model_last)) ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic model_reset();
        model_rej  = 0;
        model_last = 0;
        model_have = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic present(input int c);
        bit ok;
        ok        = legal(c);
        rnd_valid = 1'b1;
        rnd_data  = 5'(c);
        tick();
        rnd_valid = 1'b0;
        model_acc = ok;
        if (ok) begin
            model_last = c;
            model_have = 1'b1;
        end else if (model_rej < 255) begin
            model_rej++;
        end
    endtask

    task automatic wait_core_start(output int n);
        n = -1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (core_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic end_run();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; rnd_valid = 1'b1; rnd_data = 5'd7; core_done = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, p_det_valid, core_start, rnd_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, p_det_valid, core_start, rnd_ready});
        end
        checks++;
        if (p_det !== 5'd0) begin
            errors++;
            $display("FAIL reset_p_det: got %0d expected 0", p_det);
        end
        checks++;
        if (rej_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_rej_cnt: got %0d expected 0", rej_cnt);
        end
        start = 1'b0; rnd_valid = 1'b0; core_done = 1'b0; rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy got %b expected 0", busy);
        end
        model_reset();
    endtask

    task automatic test_basic();
        int lat;
        lat = -1;
        start = 1'b1; rnd_valid = 1'b1; rnd_data = 5'd7;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            start = 1'b0;
            if (core_start === 1'b1) begin
                lat = i;
                break;
            end
        end
        rnd_valid  = 1'b0;
        model_last = 7;
        model_have = 1'b1;
        checks++;
        if (lat != 2 + SETTLE_CYC) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, 2 + SETTLE_CYC);
        end
        checks++;
        if ({p_det, p_det_valid, busy} !== {5'd7, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL basic_run_outputs: p_det=%0d valid=%b busy=%b expected 7 1 1", p_det, p_det_valid, busy);
        end
        tick();
        checks++;
        if ({core_start, p_det_valid} !== 2'b01) begin
            errors++;
            $display("FAIL basic_pulse_width: core_start=%b valid=%b expected 0 1", core_start, p_det_valid);
        end
        end_run();
        checks++;
        if ({busy, p_det_valid, p_det} !== {1'b0, 1'b0, 5'd7}) begin
            errors++;
            $display("FAIL basic_idle_retain: busy=%b valid=%b p_det=%0d expected 0 0 7", busy, p_det_valid, p_det);
        end
    endtask

    task automatic test_reject();
        int cands[3];
        int rdy;
        int n;
        cands = '{0, 31, 12};
        rdy   = 0;
        do_start();
        for (int i = 0; i < 3; i++) begin
            if (rnd_ready === 1'b1) rdy++;
            present(cands[i]);
        end
        checks++;
        if (rdy != 3 || rnd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reject_ready: high cycles got %0d expected 3, now %b expected 0", rdy, rnd_ready);
        end
        checks++;
        if (rej_cnt !== 8'(model_rej)) begin
            errors++;
            $display("FAIL reject_count: got %0d expected %0d", rej_cnt, model_rej);
        end
        checks++;
        if (p_det !== 5'd12 || p_det_valid !== 1'b1) begin
            errors++;
            $display("FAIL reject_p_det: got %0d valid %b expected 12 1", p_det, p_det_valid);
        end
        wait_core_start(n);
        checks++;
        if (n != SETTLE_CYC) begin
            errors++;
            $display("FAIL reject_settle: got %0d expected %0d", n, SETTLE_CYC);
        end
        end_run();
    endtask

    task automatic test_repeat();
        int n;
        int base;
        int exp_p;
        int exp_rej;
        do_start();
        present(5);
        wait_core_start(n);
        end_run();
        base = model_rej;
        do_start();
        present(5);
        if (!model_acc) present(9);
`ifdef P_DET_NO_REPEAT_EN
        exp_p   = 9;
        exp_rej = base + 1;
`else
        exp_p   = 5;
        exp_rej = base;
`endif
        checks++;
        if (p_det !== 5'(exp_p)) begin
            errors++;
            $display("FAIL repeat_p_det: got %0d expected %0d", p_det, exp_p);
        end
        checks++;
        if (rej_cnt !== 8'(exp_rej)) begin
            errors++;
            $display("FAIL repeat_rej_cnt: got %0d expected %0d", rej_cnt, exp_rej);
        end
        wait_core_start(n);
        end_run();
    endtask

    task automatic test_core_done();
        int n;
        end_run();
        checks++;
        if ({busy, rnd_ready} !== 2'b00) begin
            errors++;
            $display("FAIL done_in_idle: busy=%b ready=%b expected 0 0", busy, rnd_ready);
        end
        do_start();
        present(11);
        end_run();
        checks++;
        if ({busy, p_det_valid, p_det} !== {1'b1, 1'b1, 5'd11}) begin
            errors++;
            $display("FAIL done_in_settle: busy=%b valid=%b p_det=%0d expected 1 1 11", busy, p_det_valid, p_det);
        end
        wait_core_start(n);
        checks++;
        if (n != SETTLE_CYC - 1) begin
            errors++;
            $display("FAIL done_settle_len: got %0d expected %0d", n, SETTLE_CYC - 1);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL run_hold: busy got %b expected 1", busy);
        end
        core_done = 1'b1; start = 1'b1;
        tick();
        core_done = 1'b0; start = 1'b0;
        checks++;
        if ({busy, p_det_valid} !== 2'b00) begin
            errors++;
            $display("FAIL done_in_run: busy=%b valid=%b expected 0 0", busy, p_det_valid);
        end
        tick();
        checks++;
        if ({busy, rnd_ready} !== 2'b00) begin
            errors++;
            $display("FAIL start_at_exit: busy=%b ready=%b expected 0 0", busy, rnd_ready);
        end
    endtask

    task automatic test_reset_in_run();
        int n;
        do_start();
        present(20);
        wait_core_start(n);
        tick();
        checks++;
        if (n != SETTLE_CYC || p_det !== 5'd20 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_run_setup: latency=%0d p_det=%0d busy=%b expected %0d 20 1", n, p_det, busy, SETTLE_CYC);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        checks++;
        if ({busy, p_det_valid, core_start, rnd_ready, p_det, rej_cnt} !== 17'd0) begin
            errors++;
            $display("FAIL rst_in_run: busy=%b valid=%b cs=%b ready=%b p_det=%0d rej=%0d expected all 0",
                     busy, p_det_valid, core_start, rnd_ready, p_det, rej_cnt);
        end
        do_start();
        present(3);
        for (int i = 1; i < SETTLE_CYC; i++) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_settle: core_start got %b expected 0", core_start);
        end
        rst_n = 1'b1;
        tick();
        model_reset();
        checks++;
        if ({core_start, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_no_pending: core_start=%b busy=%b expected 0 0", core_start, busy);
        end
    endtask

    task automatic test_saturate();
        int n;
        do_start();
        for (int i = 0; i < 300; i++) begin
            present((i % 2 == 0) ? 0 : 31);
            if (i == 99) begin
                checks++;
                if (rej_cnt !== 8'(model_rej)) begin
                    errors++;
                    $display("FAIL sat_midway: got %0d expected %0d", rej_cnt, model_rej);
                end
            end
        end
        checks++;
        if (rej_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_value: got %0d expected 255", rej_cnt);
        end
        checks++;
        if ({rnd_ready, p_det_valid, p_det} !== {1'b1, 1'b0, 5'(model_last)}) begin
            errors++;
            $display("FAIL sat_in_draw: ready=%b valid=%b p_det=%0d expected 1 0 %0d", rnd_ready, p_det_valid, p_det, model_last);
        end
        present(17);
        wait_core_start(n);
        end_run();
        checks++;
        if (rej_cnt !== 8'd255 || n != SETTLE_CYC) begin
            errors++;
            $display("FAIL sat_hold: rej=%0d latency=%0d expected 255 %0d", rej_cnt, n, SETTLE_CYC);
        end
    endtask

    task automatic test_random();
        int c;
        int sel;
        int lat;
        int bad;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 3)) begin
                core_done = 1'($urandom_range(0, 1));
                rnd_valid = 1'($urandom_range(0, 1));
                rnd_data  = 5'($urandom);
                tick();
            end
            core_done = 1'b0;
            rnd_valid = 1'b0;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rnd_idle_noise: busy got %b expected 0", busy);
            end
            do_start();
            model_acc = 1'b0;
            for (int it = 0; it < 200 && !model_acc; it++) begin
                if (it >= 100) begin
                    present((model_last % P_MAX) + 1);
                end else if ($urandom_range(0, 3) == 0) begin
                    rnd_valid = 1'b0;
                    rnd_data  = 5'($urandom);
                    tick();
                end else begin
                    sel = int'($urandom_range(0, 5));
                    c = (sel == 0) ? 0 : (sel == 1) ? 31 : (sel == 2) ? model_last : int'($urandom_range(0, 31));
                    present(c);
                end
            end
            checks++;
            if ({p_det, rej_cnt, p_det_valid} !== {5'(model_last), 8'(model_rej), 1'b1}) begin
                errors++;
                $display("FAIL rnd_accept: p_det=%0d rej=%0d valid=%b expected %0d %0d 1",
                         p_det, rej_cnt, p_det_valid, model_last, model_rej);
            end
            wait_core_start(lat);
            checks++;
            if (lat != SETTLE_CYC) begin
                errors++;
                $display("FAIL rnd_latency: got %0d expected %0d", lat, SETTLE_CYC);
            end
            bad = 0;
            repeat ($urandom_range(0, 5)) begin
                start     = 1'($urandom_range(0, 1));
                rnd_valid = 1'b1;
                rnd_data  = 5'd0;
                tick();
                if (p_det !== 5'(model_last) || p_det_valid !== 1'b1 || rej_cnt !== 8'(model_rej)) bad++;
            end
            start = 1'b0;
            rnd_valid = 1'b0;
            end_run();
            checks++;
            if (bad != 0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rnd_run_hold: unstable cycles %0d busy=%b expected 0 0", bad, busy);
            end
            $display("txn %0d: p_det=%0d rej_cnt=%0d latency=%0d", t, p_det, rej_cnt, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_repeat();
        test_core_done();
        test_reset_in_run();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
